// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the slave FSM state type.
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;

endpackage

// File: rtl/ahbl_lane_decode.sv
// Byte-lane enables and alignment check for one AHB-Lite transfer.
module ahbl_lane_decode
    import ahbl_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] size,
    output logic [3:0] lanes,
    output logic       illegal
);

    always_comb begin
        lanes   = 4'b0000;
        illegal = 1'b0;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << addr;
            HSIZE_HALF: begin
                lanes   = addr[1] ? 4'b1100 : 4'b0011;
                illegal = addr[0];
            end
            HSIZE_WORD: begin
                lanes   = 4'b1111;
                illegal = (addr != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states, byte lanes and a
// two-cycle ERROR response for misaligned or oversized transfers.
module ahbl_sram_slave
    import ahbl_pkg::*;
#(
    parameter int AW          = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int IW    = AW - 2;
    localparam int DEPTH = 1 << IW;

    logic [31:0] mem [DEPTH];

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          hreadyout_q, hreadyout_d;
    logic          hresp_q, hresp_d;
    logic [31:0]   hrdata_q, hrdata_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic [3:0]    lanes_q, lanes_d;
    logic          dp_q, dp_d;

    logic [3:0]    dec_lanes;
    logic          dec_illegal;
    logic          accept;
    logic          commit;
    logic          rd_load;
    logic [IW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic [31:0]   wmask;
    logic          unused_bits;

    assign unused_bits = ^{HTRANS[0], HADDR[31:AW]};

    ahbl_lane_decode u_lane_decode (
        .addr    (HADDR[1:0]),
        .size    (HSIZE),
        .lanes   (dec_lanes),
        .illegal (dec_illegal)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mask
            assign wmask[8*gi +: 8] = {8{lanes_q[gi]}};
        end
    endgenerate

    // A new address phase is only taken while no data phase is stalling the bus.
    assign accept = HSEL && HREADY && HTRANS[1] &&
                    ((state_q == ST_IDLE) || (state_q == ST_ERR2));
    assign commit = dp_q && write_q && hreadyout_q && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        idx_d       = idx_q;
        write_d     = write_q;
        lanes_d     = lanes_q;
        dp_d        = dp_q;
        rd_load     = 1'b0;
        rd_idx      = HADDR[AW-1:2];
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d     = ST_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
                dp_d        = 1'b0;
                if (accept) begin
                    idx_d   = HADDR[AW-1:2];
                    write_d = HWRITE;
                    lanes_d = dec_lanes;
                    if (dec_illegal) begin
                        state_d     = ST_ERR1;
                        hreadyout_d = 1'b0;
                        hresp_d     = HRESP_ERROR;
                    end else if (WAIT_STATES == 0) begin
                        dp_d    = 1'b1;
                        rd_load = !HWRITE;
                    end else begin
                        state_d     = ST_WAIT;
                        hreadyout_d = 1'b0;
                        cnt_d       = 3'(WAIT_STATES - 1);
                        dp_d        = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d     = ST_IDLE;
                    hreadyout_d = 1'b1;
                    rd_load     = !write_q;
                    rd_idx      = idx_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR1: begin
                state_d     = ST_ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A read landing on a word being written this edge sees the new lanes.
    always_comb begin
        rd_word = mem[rd_idx];
        if (commit && (idx_q == rd_idx)) begin
            rd_word = (HWDATA & wmask) | (rd_word & ~wmask);
        end
        hrdata_d = rd_load ? rd_word : hrdata_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= 32'h0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            lanes_q     <= 4'b0000;
            dp_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            idx_q       <= idx_d;
            write_q     <= write_d;
            lanes_q     <= lanes_d;
            dp_q        <= dp_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit && !HRESET) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_q[i]) begin
                    mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;

endmodule
